// File: rtl/tidc_req_capture_if.sv
// Signal bundle between the masters/L1 arbiter, the request capture stage and the directory controller.
interface tidc_req_capture_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Masters' A/C request payloads (both masters packed, master0 in the low half)
  logic [1:0]          a_valid_i;
  logic [5:0]          a_opcode_i;
  logic [5:0]          a_param_i;
  logic [5:0]          a_size_i;
  logic [2*SRC_W-1:0]  a_source_i;
  logic [2*ADDR_W-1:0] a_address_i;
  logic [1:0]          c_valid_i;
  logic [5:0]          c_opcode_i;
  logic [5:0]          c_param_i;
  logic [5:0]          c_size_i;
  logic [2*SRC_W-1:0]  c_source_i;
  logic [2*ADDR_W-1:0] c_address_i;
  logic [2*DATA_W-1:0] c_data_i;

  // Arbiter grant
  logic                arb_valid;
  logic [1:0]          arb_channel;
  logic                arb_master_id;
  logic                arb_ready;

  // Directory-side FIFO head
  logic                out_valid;
  logic                out_ready;
  logic                out_channel;
  logic                out_master_id;
  logic [2:0]          out_opcode;
  logic [2:0]          out_param;
  logic [2:0]          out_size;
  logic [SRC_W-1:0]    out_source;
  logic [ADDR_W-1:0]   out_address;
  logic [DATA_W-1:0]   out_data;
  logic                out_first;
  logic                out_last;

  // Status / debug
  logic [CNT_W-1:0]    fifo_count;
  logic                burst_active;
  logic                err_o;
  logic                dbg_state;

  // Handshakes: a grant transfers on the cycle arb_valid && arb_ready are both high; a FIFO
  // entry transfers on out_valid && out_ready. Ready never depends on valid, and the head
  // entry is held unchanged while out_valid is high and out_ready is low.
  modport slave (
    input  a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
    input  c_valid_i, c_opcode_i, c_param_i, c_size_i, c_source_i, c_address_i, c_data_i,
    input  arb_valid, arb_channel, arb_master_id, out_ready,
    output arb_ready, out_valid, out_channel, out_master_id, out_opcode, out_param,
    output out_size, out_source, out_address, out_data, out_first, out_last,
    output fifo_count, burst_active, err_o, dbg_state
  );

  modport master (
    output a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
    output c_valid_i, c_opcode_i, c_param_i, c_size_i, c_source_i, c_address_i, c_data_i,
    output arb_valid, arb_channel, arb_master_id, out_ready,
    input  arb_ready, out_valid, out_channel, out_master_id, out_opcode, out_param,
    input  out_size, out_source, out_address, out_data, out_first, out_last,
    input  fifo_count, burst_active, err_o, dbg_state
  );
endinterface

// File: rtl/tidc_req_capture.sv
// Captures the arbiter-granted A/C request into a FIFO, locking the grant to one master for
// the full duration of a multi-beat Channel C data message.
module tidc_req_capture #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int SRC_W      = 4,
  parameter int LINE_BEATS = 4,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst_n,
  tidc_req_capture_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(LINE_BEATS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic              channel;
    logic              master_id;
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } entry_t;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              lock_id_q, lock_id_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [DEPTH];

  // Granted master's payload on each channel
  logic [2:0]        a_op, a_par, a_sz;
  logic [SRC_W-1:0]  a_src;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        c_op, c_par, c_sz;
  logic [SRC_W-1:0]  c_src;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;

  always_comb begin
    if (bus.arb_master_id) begin
      a_op   = bus.a_opcode_i[5:3];
      a_par  = bus.a_param_i[5:3];
      a_sz   = bus.a_size_i[5:3];
      a_src  = bus.a_source_i[2*SRC_W-1:SRC_W];
      a_addr = bus.a_address_i[2*ADDR_W-1:ADDR_W];
      c_op   = bus.c_opcode_i[5:3];
      c_par  = bus.c_param_i[5:3];
      c_sz   = bus.c_size_i[5:3];
      c_src  = bus.c_source_i[2*SRC_W-1:SRC_W];
      c_addr = bus.c_address_i[2*ADDR_W-1:ADDR_W];
      c_data = bus.c_data_i[2*DATA_W-1:DATA_W];
    end else begin
      a_op   = bus.a_opcode_i[2:0];
      a_par  = bus.a_param_i[2:0];
      a_sz   = bus.a_size_i[2:0];
      a_src  = bus.a_source_i[SRC_W-1:0];
      a_addr = bus.a_address_i[ADDR_W-1:0];
      c_op   = bus.c_opcode_i[2:0];
      c_par  = bus.c_param_i[2:0];
      c_sz   = bus.c_size_i[2:0];
      c_src  = bus.c_source_i[SRC_W-1:0];
      c_addr = bus.c_address_i[ADDR_W-1:0];
      c_data = bus.c_data_i[DATA_W-1:0];
    end
  end

  logic sel_valid;
  logic is_c;
  logic full;
  logic arb_ready_w;
  logic accept;
  logic pop;
  logic is_data_op;

  always_comb begin
    unique case (bus.arb_channel)
      2'd0:    sel_valid = bus.a_valid_i[bus.arb_master_id];
      2'd1:    sel_valid = bus.c_valid_i[bus.arb_master_id];
      default: sel_valid = 1'b0;
    endcase
  end

  assign is_c        = (bus.arb_channel == 2'd1);
  assign full        = (count_q == CNT_W'(DEPTH));
  // During a burst only the locked master's C channel may proceed
  assign arb_ready_w = rst_n && !full &&
                       ((state_q == S_IDLE) || (is_c && (bus.arb_master_id == lock_id_q)));
  assign accept      = bus.arb_valid && arb_ready_w && sel_valid && !bus.arb_channel[1];
  assign pop         = (count_q != '0) && bus.out_ready;
  assign is_data_op  = is_c && ((c_op == 3'd5) || (c_op == 3'd7));

  entry_t wr_entry;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    lock_id_d  = lock_id_q;

    wr_entry.channel   = is_c;
    wr_entry.master_id = bus.arb_master_id;
    wr_entry.opcode    = is_c ? c_op   : a_op;
    wr_entry.param     = is_c ? c_par  : a_par;
    wr_entry.size      = is_c ? c_sz   : a_sz;
    wr_entry.source    = is_c ? c_src  : a_src;
    wr_entry.address   = is_c ? c_addr : a_addr;
    wr_entry.data      = '0;
    wr_entry.first     = 1'b1;
    wr_entry.last      = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (is_data_op) begin
          wr_entry.data = c_data;
          wr_entry.last = 1'b0;
        end
        if (accept && is_data_op) begin
          lock_id_d  = bus.arb_master_id;
          beat_cnt_d = BEAT_W'(1);
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        // Later beats always carry data, whatever opcode they present
        wr_entry.data  = c_data;
        wr_entry.first = 1'b0;
        wr_entry.last  = (beat_cnt_q == BEAT_W'(LINE_BEATS - 1));
        if (accept) begin
          if (wr_entry.last) begin
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop    ? rptr_q + 1'b1 : rptr_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = bus.arb_valid && bus.arb_channel[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      lock_id_q  <= 1'b0;
      err_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      lock_id_q  <= lock_id_d;
      err_q      <= err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  entry_t head;
  assign head = mem_q[rptr_q];

  assign bus.arb_ready     = arb_ready_w;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_channel   = head.channel;
  assign bus.out_master_id = head.master_id;
  assign bus.out_opcode    = head.opcode;
  assign bus.out_param     = head.param;
  assign bus.out_size      = head.size;
  assign bus.out_source    = head.source;
  assign bus.out_address   = head.address;
  assign bus.out_data      = head.data;
  assign bus.out_first     = head.first;
  assign bus.out_last      = head.last;
  assign bus.fifo_count    = count_q;
  assign bus.burst_active  = (state_q == S_BURST);
  assign bus.err_o         = err_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: doc/tidc_req_capture.md
Name: tidc_req_capture

Overview:
- Stage directly downstream of the 2-master L1 request arbiter in the TIDC system.
- Takes the arbiter's registered grant (arb_valid, arb_channel, arb_master_id) and muxes the granted master's Channel A/C payload.
- Enforces beat-atomicity of multi-beat Channel C data messages by locking the grant to one master until the last beat.
- Buffers accepted beats in a DEPTH-entry FIFO that feeds the directory controller, and returns arb_ready to the arbiter.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, beat data width (Channel C only)
SRC_W, 4, TileLink source ID width
LINE_BEATS, 4, beats per data-bearing C message (power of 2, >=2)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
a_valid_i  in  2  per-master A valid (same wires as arbiter input)
a_opcode_i  in  6  2x3 packed, master0 in [2:0]
a_param_i  in  6  2x3 packed
a_size_i  in  6  2x3 packed
a_source_i  in  2*SRC_W  packed
a_address_i  in  2*ADDR_W  packed
c_valid_i  in  2  per-master C valid
c_opcode_i  in  6  2x3 packed
c_param_i  in  6  2x3 packed
c_size_i  in  6  2x3 packed
c_source_i  in  2*SRC_W  packed
c_address_i  in  2*ADDR_W  packed
c_data_i  in  2*DATA_W  packed
arb_valid  in  1  arbiter grant valid
arb_channel  in  2  0=A, 1=C; other values illegal
arb_master_id  in  1  granted master
arb_ready  out  1  capture ready, to arbiter
out_valid  out  1  FIFO head valid
out_ready  in  1  directory controller ready
out_channel  out  1  0=A, 1=C
out_master_id  out  1  master of head entry
out_opcode / out_param / out_size  out  3 each  head fields
out_source  out  SRC_W  head source
out_address  out  ADDR_W  head address
out_data  out  DATA_W  head data (0 for A and dataless C)
out_first / out_last  out  1 each  beat position flags (both 1 for single-beat)
fifo_count  out  $clog2(DEPTH)+1  occupancy
burst_active  out  1  FSM in C_BURST
err_o  out  1  one-cycle pulse on illegal grant

Behaviour:
- Reset: rst_n low at any posedge, including mid-burst, gives FSM=IDLE, beat_cnt=0, FIFO empty. Outputs: out_valid=0, fifo_count=0, burst_active=0, err_o=0. While rst_n low, arb_ready=0 (combinational gate).
- sel_valid: the granted master's a_valid_i or c_valid_i bit for arb_channel.
- arb_ready (combinational) = !full && (IDLE || (arb_channel==1 && arb_master_id==lock_id)).
- No full bypass: a full FIFO deasserts arb_ready even when out_ready=1.
- accept = arb_valid && arb_ready && sel_valid && arb_channel<=1.
  - Grant with sel_valid=0 (stale grant) enqueues nothing.
  - Grant with arb_channel>=2: no enqueue; err_o pulses the next cycle.
- Data-bearing C opcodes are ProbeAckData=5 and ReleaseData=7; these are LINE_BEATS beats. All A opcodes and C ProbeAck=4, Release=6 are single-beat.
- FSM:
  - IDLE: accept of C opcode 5/7 -> enqueue beat with first=1, last=0; lock_id=arb_master_id; beat_cnt=1; go to C_BURST. Any other accept -> enqueue with first=last=1; stay in IDLE.
  - C_BURST: only C grants from lock_id are accepted. Any other grant, including any A grant, sees arb_ready=0.
  - In C_BURST, each accept enqueues with first=0 and increments beat_cnt. The beat accepted with beat_cnt==LINE_BEATS-1 has last=1 and returns the FSM to IDLE with beat_cnt=0.
  - In C_BURST, opcode/param/size/source/address are taken from the current beat; no consistency check is made.
- FIFO:
  - Write on accept; read on out_valid && out_ready.
  - Simultaneous read and write when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
  - An accepted beat is visible at out_* in the next cycle when the FIFO was empty (1-cycle latency).
  - out_* hold stable while out_valid && !out_ready.
- out_data is forced to 0 for entries without data.

Test Plan:
- Master1 A AcquireBlock (op 6, addr 0x1000, src 3), grant ch=0 id=1, out_ready=1 -> one enqueue; next cycle out_valid=1, out_channel=0, out_master_id=1, address 0x1000, first=last=1.
- Master0 C ReleaseData (op 7), 4 beats with data 0xA0..0xA3, grant held -> 4 entries; first=1 only on 0xA0, last=1 only on 0xA3; burst_active=1 between beats 1 and 3; FSM returns to IDLE.
- Mid-burst lock: after beat 2 of master0 ReleaseData, arbiter grants ch=1 id=1, then ch=0 id=0 -> arb_ready=0 for both; no enqueue. Regrant of id=0 completes beats 3-4.
- Backpressure at DEPTH=4, out_ready=0: five single-beat A requests -> fifo_count saturates at 4 and arb_ready=0. One dequeue cycle -> arb_ready=1 the cycle after count drops to 3.
- Stale grant (arb_valid=1, a_valid_i=0) and grant with arb_channel=2 -> no enqueue; err_o=1 for exactly one cycle after the illegal grant only.
- rst_n=0 for one cycle after beat 2 of a burst, with 2 entries queued -> out_valid=0, fifo_count=0, burst_active=0. A fresh A request is then accepted in IDLE.
